// File: rtl/modular_exponentiation_if.sv
// Level ready/done bus between modexp and the modular multiplier stage.
// master = modexp (requester), slave = modmult (responder).
interface modular_exponentiation_if #(
  parameter int WIDTH = 32
);
  logic             mm_ready;
  logic [WIDTH-1:0] mm_base;
  logic [WIDTH-1:0] mm_power;
  logic [WIDTH-1:0] mm_denominator;
  logic             mm_done;
  logic [WIDTH-1:0] mm_result;

  modport master (
    output mm_ready,
    output mm_base,
    output mm_power,
    output mm_denominator,
    input  mm_done,
    input  mm_result
  );

  modport slave (
    input  mm_ready,
    input  mm_base,
    input  mm_power,
    input  mm_denominator,
    output mm_done,
    output mm_result
  );
endinterface

// File: rtl/modular_exponentiation.sv
// Right-to-left square-and-multiply modexp over an external modmult stage.
// Optional MODEXP_WATCHDOG_EN bounds each modmult request by TIMEOUT_CYCLES.
module modular_exponentiation #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      modexp_ready,
  input  logic [WIDTH-1:0]          base,
  input  logic [WIDTH-1:0]          exponent,
  input  logic [WIDTH-1:0]          modulus,
  output logic                      modexp_done,
  output logic [WIDTH-1:0]          result,
  output logic                      error,
  modular_exponentiation_if.master  mm
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_REDUCE = 4'd2;
  localparam logic [3:0] S_CHECK  = 4'd3;
  localparam logic [3:0] S_MUL    = 4'd4;
  localparam logic [3:0] S_SHIFT  = 4'd5;
  localparam logic [3:0] S_SQR    = 4'd6;
  localparam logic [3:0] S_WAIT   = 4'd7;
  localparam logic [3:0] S_REL    = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

  localparam logic [1:0] OP_RED = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_SQR = 2'd2;

  logic [3:0]       state;
  logic [1:0]       op;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] e_shr;

  assign e_shr = e >> 1;

`ifdef MODEXP_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] wd;
  logic          wd_hit;
  assign wd_hit = (wd == CW'(TIMEOUT_CYCLES - 1));
`else
  wire unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      op                <= OP_RED;
      r                 <= '0;
      b                 <= '0;
      e                 <= '0;
      n                 <= '0;
      modexp_done       <= 1'b0;
      result            <= '0;
      error             <= 1'b0;
      mm.mm_ready       <= 1'b0;
      mm.mm_base        <= '0;
      mm.mm_power       <= '0;
      mm.mm_denominator <= '0;
`ifdef MODEXP_WATCHDOG_EN
      wd                <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (modexp_ready) begin
            n     <= modulus;
            e     <= exponent;
            b     <= base;
            r     <= WIDTH'(1);
            error <= 1'b0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (n == '0) begin
            error       <= 1'b1;
            result      <= '0;
            modexp_done <= 1'b1;
            state       <= S_DONE;
          end else if (n == WIDTH'(1)) begin
            result      <= '0;
            modexp_done <= 1'b1;
            state       <= S_DONE;
          end else begin
            state <= S_REDUCE;
          end
        end
        // REDUCE computes b*1 mod n so every later operand is below n
        S_REDUCE, S_MUL, S_SQR: begin
          mm.mm_ready       <= 1'b1;
          mm.mm_base        <= (state == S_MUL) ? r : b;
          mm.mm_power       <= (state == S_REDUCE) ? WIDTH'(1) : b;
          mm.mm_denominator <= n;
          op    <= (state == S_REDUCE) ? OP_RED :
                   (state == S_MUL)    ? OP_MUL : OP_SQR;
          state <= S_WAIT;
`ifdef MODEXP_WATCHDOG_EN
          wd    <= '0;
`endif
        end
        S_WAIT: begin
`ifdef MODEXP_WATCHDOG_EN
          wd <= wd + CW'(1);
          if (wd_hit) begin
            mm.mm_ready <= 1'b0;
            error       <= 1'b1;
            result      <= '0;
            modexp_done <= 1'b1;
            state       <= S_DONE;
          end else
`endif
          if (mm.mm_done) begin
            mm.mm_ready <= 1'b0;
            if (op == OP_MUL) r <= mm.mm_result;
            else              b <= mm.mm_result;
            state <= S_REL;
          end
        end
        S_REL: begin
`ifdef MODEXP_WATCHDOG_EN
          wd <= wd + CW'(1);
          if (wd_hit) begin
            error       <= 1'b1;
            result      <= '0;
            modexp_done <= 1'b1;
            state       <= S_DONE;
          end else
`endif
          if (!mm.mm_done) begin
            state <= (op == OP_MUL) ? S_SHIFT : S_CHECK;
          end
        end
        S_CHECK: begin
          if (e == '0) begin
            result      <= r;
            modexp_done <= 1'b1;
            state       <= S_DONE;
          end else if (e[0]) begin
            state <= S_MUL;
          end else begin
            state <= S_SHIFT;
          end
        end
        // the square after the top exponent bit is never needed
        S_SHIFT: begin
          e     <= e_shr;
          state <= (e_shr == '0) ? S_CHECK : S_SQR;
        end
        S_DONE: begin
          if (!modexp_ready) begin
            modexp_done <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_exponentiation.sv
// Self-checking bench for modular_exponentiation with a modmult responder.
module tb_modular_exponentiation;
  localparam int W  = 32;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         modexp_ready = 1'b0;
  logic [W-1:0] base = '0;
  logic [W-1:0] exponent = '0;
  logic [W-1:0] modulus = '0;
  logic         modexp_done;
  logic [W-1:0] result;
  logic         error;

  modular_exponentiation_if #(.WIDTH(W)) mm_if();

  modular_exponentiation #(
    .WIDTH(W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .modexp_ready(modexp_ready),
    .base(base),
    .exponent(exponent),
    .modulus(modulus),
    .modexp_done(modexp_done),
    .result(result),
    .error(error),
    .mm(mm_if)
  );

  always #5 clk = ~clk;

  // modmult responder: variable latency, holds done until ready drops
  int lat = 0;
  bit stub_hold = 1'b0;
  int cnt = 0;
  always @(posedge clk) begin
    if (reset) begin
      mm_if.mm_done   <= 1'b0;
      mm_if.mm_result <= '0;
      cnt             <= 0;
    end else if (mm_if.mm_ready && !mm_if.mm_done) begin
      if (!stub_hold && cnt >= lat) begin
        mm_if.mm_done   <= 1'b1;
        mm_if.mm_result <= W'((64'(mm_if.mm_base) * 64'(mm_if.mm_power))
                              % 64'(mm_if.mm_denominator));
        cnt <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else if (!mm_if.mm_ready) begin
      mm_if.mm_done <= 1'b0;
    end
  end

  // protocol monitor: request edges, re-request while done, operand churn
  int req_total = 0;
  int viol_total = 0;
  logic p_rdy = 1'b0;
  logic p_done = 1'b0;
  logic [W-1:0] p_a = '0, p_b = '0, p_n = '0;
  always @(negedge clk) begin
    if (mm_if.mm_ready && !p_rdy) begin
      req_total <= req_total + 1;
      if (p_done) viol_total <= viol_total + 1;
    end else if (mm_if.mm_ready &&
                 (mm_if.mm_base != p_a || mm_if.mm_power != p_b ||
                  mm_if.mm_denominator != p_n)) begin
      viol_total <= viol_total + 1;
    end
    p_rdy  <= mm_if.mm_ready;
    p_done <= mm_if.mm_done;
    p_a    <= mm_if.mm_base;
    p_b    <= mm_if.mm_power;
    p_n    <= mm_if.mm_denominator;
  end

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] e;
    logic [W-1:0] n;
    logic [W-1:0] res;
    logic         err;
    int           reqs;
  } vec_t;

  vec_t vt[11];
  vec_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int req0 = 0;
  int viol0 = 0;

  function automatic logic [W-1:0] ref_modexp(logic [W-1:0] bb,
                                               logic [W-1:0] ee,
                                               logic [W-1:0] nn);
    logic [63:0] acc;
    if (nn <= 1) return '0;
    acc = 64'd1;
    for (int i = W - 1; i >= 0; i--) begin
      acc = (acc * acc) % 64'(nn);
      if (ee[i]) acc = (acc * 64'(bb)) % 64'(nn);
    end
    return W'(acc);
  endfunction

  function automatic int ref_reqs(logic [W-1:0] ee, logic [W-1:0] nn);
    int bl;
    if (nn <= 1) return 0;
    if (ee == '0) return 1;
    bl = 0;
    for (int i = 0; i < W; i++) if (ee[i]) bl = i + 1;
    return 1 + $countones(ee) + bl - 1;
  endfunction

  function automatic vec_t mk(logic [W-1:0] bb, logic [W-1:0] ee,
                              logic [W-1:0] nn, logic [W-1:0] rr,
                              logic er, int q);
    vec_t v;
    v.b = bb; v.e = ee; v.n = nn; v.res = rr; v.err = er; v.reqs = q;
    return v;
  endfunction

  function automatic vec_t mk_ref(logic [W-1:0] bb, logic [W-1:0] ee,
                                  logic [W-1:0] nn);
    return mk(bb, ee, nn, ref_modexp(bb, ee, nn), (nn == '0),
              ref_reqs(ee, nn));
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic start_op(input vec_t v, input bit push);
    @(negedge clk);
    base = v.b;
    exponent = v.e;
    modulus = v.n;
    modexp_ready = 1'b1;
    req0 = req_total;
    viol0 = viol_total;
    if (push) sbq.push_back(v);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!modexp_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (!modexp_done) check("done_timeout", 64'(modexp_done), 64'd1);
  endtask

  task automatic finish_op(input bit hold);
    vec_t x;
    if (sbq.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
      return;
    end
    x = sbq.pop_front();
    check("result", 64'(result), 64'(x.res));
    check("error", 64'(error), 64'(x.err));
    check("requests", 64'(req_total - req0), 64'(x.reqs));
    check("protocol", 64'(viol_total - viol0), 64'd0);
    if (hold) begin
      repeat (3) begin
        @(negedge clk);
        check("done_held", 64'(modexp_done), 64'd1);
      end
      check("result_held", 64'(result), 64'(x.res));
    end
    modexp_ready = 1'b0;
    @(negedge clk);
    check("done_drop", 64'(modexp_done), 64'd0);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_done"}, 64'(modexp_done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_mm_ready"}, 64'(mm_if.mm_ready), 64'd0);
    check({tag, "_mm_base"}, 64'(mm_if.mm_base), 64'd0);
    check({tag, "_mm_power"}, 64'(mm_if.mm_power), 64'd0);
    check({tag, "_mm_den"}, 64'(mm_if.mm_denominator), 64'd0);
  endtask

  initial begin
    int cyc;
    int guard;
    vt[0]  = mk(32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 7);
    vt[1]  = mk(32'd2, 32'd10, 32'd1000, 32'd24, 1'b0, 6);
    vt[2]  = mk(32'd7, 32'd0, 32'd13, 32'd1, 1'b0, 1);
    vt[3]  = mk(32'd9, 32'd5, 32'd1, 32'd0, 1'b0, 0);
    vt[4]  = mk(32'd5, 32'd3, 32'd0, 32'd0, 1'b1, 0);
    vt[5]  = mk(32'd3, 32'd5, 32'd7, 32'd5, 1'b0, 5);
    vt[6]  = mk(32'd10, 32'd1, 32'd7, 32'd3, 1'b0, 2);
    vt[7]  = mk_ref(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    vt[8]  = mk_ref($urandom, $urandom, $urandom | 32'h8000_0001);
    vt[9]  = mk_ref($urandom, 32'($urandom_range(0, 255)),
                    32'($urandom_range(2, 1000)));
    vt[10] = mk($urandom, $urandom, 32'd0, 32'd0, 1'b1, 0);

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    foreach (vt[i]) begin
      lat = $urandom_range(0, 3);
      start_op(vt[i], 1'b1);
      wait_done(cyc);
      if (vt[i].n == '0) check("m0_latency", 64'(cyc <= 3), 64'd1);
      finish_op(1'b1);
    end

    // start level dropped mid-operation: computation still completes
    lat = 1;
    start_op(vt[1], 1'b1);
    repeat (2) @(negedge clk);
    modexp_ready = 1'b0;
    wait_done(cyc);
    finish_op(1'b0);

    // reset during the third request's wait, then a clean restart
    lat = 3;
    start_op(vt[0], 1'b0);
    guard = 0;
    while (!((req_total - req0) == 3 && mm_if.mm_ready) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_wait3", 64'((req_total - req0) == 3), 64'd1);
    reset = 1'b1;
    modexp_ready = 1'b0;
    @(negedge clk);
    check_zero("abort");
    reset = 1'b0;
    lat = 0;
    start_op(vt[5], 1'b1);
    wait_done(cyc);
    finish_op(1'b1);

`ifdef MODEXP_WATCHDOG_EN
    stub_hold = 1'b1;
    start_op(mk(32'd4, 32'd13, 32'd497, 32'd0, 1'b1, 1), 1'b1);
    wait_done(cyc);
    check("wd_mm_ready", 64'(mm_if.mm_ready), 64'd0);
    finish_op(1'b0);
    stub_hold = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/modular_exponentiation.md
Name: modular_exponentiation

Overview:
- Computes result = base^exponent mod modulus with right-to-left binary square-and-multiply.
- Sits directly upstream of the modular multiplier stage. Sequences every multiply-and-reduce request through that stage's level handshake.
- Exposes the same level ready/done handshake to the RSA top-level controller for encrypt and decrypt.

Parameters:
- WIDTH, 32, operand and result width in bits.
- TIMEOUT_CYCLES, 4096, watchdog limit per modmult request. Used only with MODEXP_WATCHDOG_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- modexp_ready  in  1  start request, level; operands sampled in IDLE.
- base  in  WIDTH  message or ciphertext.
- exponent  in  WIDTH  public or private exponent.
- modulus  in  WIDTH  n.
- modexp_done  out  1  result valid; held until modexp_ready is low.
- result  out  WIDTH  base^exponent mod modulus.
- error  out  1  modulus==0, or watchdog expiry.
- mm_ready  out  1  request to the modmult stage, level.
- mm_base  out  WIDTH  multiplicand A.
- mm_power  out  WIDTH  multiplicand B.
- mm_denominator  out  WIDTH  reduction modulus (the latched modulus).
- mm_done  in  1  modmult result valid.
- mm_result  in  WIDTH  (A*B) mod n.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - State goes to IDLE.
  - modexp_done, error, mm_ready, result, mm_base, mm_power, mm_denominator all 0.
  - Internal registers r, b, e, n cleared.
  - Reset mid-operation aborts immediately. mm_ready drops the next cycle; the partner stage is reset by the same reset.
- IDLE:
  - Waits for modexp_ready=1.
  - On the start cycle latches n=modulus, e=exponent, b=base; r=1; error cleared.
- LOAD:
  - modulus==0: error=1, result=0, go to DONE with no modmult requests.
  - modulus==1: result=0, go to DONE.
  - Otherwise go to REDUCE.
- REDUCE: issue request A=b, B=1; on completion b=mm_result. This makes b < n.
- CHECK:
  - e==0: result=r, go to DONE.
  - e[0]==1: go to MUL.
  - Otherwise go to SHIFT.
- MUL: request A=r, B=b; on completion r=mm_result.
- SHIFT: e = e>>1 (logical).
  - New e==0: go to CHECK (finishes there).
  - Otherwise go to SQR.
- SQR: request A=b, B=b; on completion b=mm_result; then go to CHECK.
- The final square is never issued.
- Total requests = 1 + popcount(exponent) + (bitlength(exponent) - 1). Exponent 0 gives 1 request.
- Request sub-sequence (REQ, WAIT, REL):
  - REQ: drive mm_base, mm_power, mm_denominator; assert mm_ready the same cycle. Operands stay stable while mm_ready=1.
  - WAIT: hold mm_ready=1 until mm_done=1, then capture mm_result and deassert mm_ready.
  - REL: wait for mm_done=0 before the next REQ. No back-to-back requests without done going low.
- DONE:
  - modexp_done=1; result stable.
  - Stays in DONE while modexp_ready=1.
  - When modexp_ready=0: modexp_done=0 next cycle, state IDLE. result and error hold until the next start.
- modexp_ready dropping mid-operation is ignored. The computation completes, then DONE lasts 1 cycle.
- modexp_ready toggling during DONE does not restart until the block has returned to IDLE.
- Width rules: all state is WIDTH bits. The correctness precondition is that the modmult stage is exact for A,B < n.

Optional Feature:
- Macro MODEXP_WATCHDOG_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES)+1 clears on each REQ and increments in WAIT and REL.
  - On reaching TIMEOUT_CYCLES: mm_ready=0, error=1, result=0, go to DONE.
- Undefined: no counter logic. WAIT and REL wait indefinitely; error is set only for modulus==0.

Test Plan:
- base=4, exponent=13, modulus=497 with the reference modmult model -> result=445, error=0, exactly 7 mm_ready rising edges, modexp_done held until modexp_ready low.
- base=2, exponent=10, modulus=1000 -> result=24, 6 requests; mm_ready never re-rises while mm_done=1.
- base=7, exponent=0, modulus=13 -> result=1, 1 request. Then base=9, exponent=5, modulus=1 -> result=0, 0 requests.
- modulus=0, any base or exponent -> error=1, result=0, modexp_done within 3 cycles of start, no requests.
- reset=1 asserted during the third WAIT of the base=4 run -> next cycle all outputs 0, state IDLE. A restart with base=3, exponent=5, modulus=7 -> result=5.
- MODEXP_WATCHDOG_EN with TIMEOUT_CYCLES=16 and a stub that never asserts mm_done -> mm_ready drops after 16 WAIT cycles, error=1, result=0, modexp_done=1.
